// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging instruction-side and data-side requests onto one
// memory port; one transaction in flight, request fields registered at grant.
module mem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit DMEM_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        favour_q, favour_d;   // 1 = data side wins the next contention
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        grant_dmem;

    always_comb begin
        state_d     = state_q;
        favour_d    = favour_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        grant_dmem  = 1'b0;

        case (state_q)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    if (imem_valid && dmem_valid) begin
                        if (ROUND_ROBIN) begin
                            grant_dmem = favour_q;
                            favour_d   = ~favour_q;
                        end else begin
                            grant_dmem = DMEM_FIRST;
                        end
                    end else begin
                        grant_dmem = dmem_valid;
                    end

                    if (grant_dmem) begin
                        state_d     = GNT_D;
                        mem_instr_d = dmem_instr;
                        mem_addr_d  = dmem_addr;
                        mem_wdata_d = dmem_wdata;
                        mem_wstrb_d = dmem_wstrb;
                    end else begin
                        state_d     = GNT_I;
                        mem_instr_d = imem_instr;
                        mem_addr_d  = imem_addr;
                        mem_wdata_d = imem_wdata;
                        mem_wstrb_d = imem_wstrb;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            favour_q    <= DMEM_FIRST;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            favour_q    <= favour_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // A transaction being reset away must not report completion.
    assign imem_ready = ~rst && (state_q == GNT_I) && mem_ready;
    assign dmem_ready = ~rst && (state_q == GNT_D) && mem_ready;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with an expected
// queue, directed scenarios plus randomized traffic, one round-robin and one fixed-priority instance.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_valid, imem_instr, imem_ready;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        dmem_valid, dmem_instr, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_valid, mem_instr, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter #(.ROUND_ROBIN(1'b1), .DMEM_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    // Fixed-priority instance (instruction side preferred), both sides always requesting.
    localparam logic [31:0] F_IADDR = 32'h0000_0400;
    localparam logic [31:0] F_DADDR = 32'h0000_0800;
    logic        f_on;
    logic        f_imem_ready, f_dmem_ready, f_mem_valid, f_mem_instr, f_busy;
    logic [31:0] f_imem_rdata, f_dmem_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wstrb;

    mem_arbiter #(.ROUND_ROBIN(1'b0), .DMEM_FIRST(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .imem_valid(f_on), .imem_instr(1'b1), .imem_addr(F_IADDR),
        .imem_wdata(32'h1111_1111), .imem_wstrb(4'h0), .imem_rdata(f_imem_rdata),
        .imem_ready(f_imem_ready),
        .dmem_valid(f_on), .dmem_instr(1'b0), .dmem_addr(F_DADDR),
        .dmem_wdata(32'h2222_2222), .dmem_wstrb(4'hF), .dmem_rdata(f_dmem_rdata),
        .dmem_ready(f_dmem_ready),
        .mem_valid(f_mem_valid), .mem_instr(f_mem_instr), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_wstrb(f_mem_wstrb), .mem_rdata(32'h5A5A_0000),
        .mem_ready(f_on), .busy(f_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: one transaction at a time, favour pointer, expected queue.
    logic [69:0] exp_q[$];         // {side, instr, addr, wdata, wstrb}
    bit          grant_log[$];     // 1 = data side
    bit          m_busy = 1'b0;
    bit          m_side = 1'b0;
    bit          m_fav  = 1'b1;
    bit          f_busy_m = 1'b0;
    int          f_i_cnt = 0;
    bit          i_rdy_seen = 1'b0, d_rdy_seen = 1'b0, mv_seen = 1'b0;

    // Requester modes: 0 no new requests, 1 random, 2 continuous, 3 manual.
    // Memory modes:    0 never ready, 1 random, 2 one cycle after mem_valid, 3 manual.
    int req_mode = 3;
    int mem_mode = 3;

    always @(negedge clk) begin
        logic [69:0] hd;
        logic        exp_ir, exp_dr, win;
        exp_ir = m_busy && !m_side && mem_ready && !rst;
        exp_dr = m_busy &&  m_side && mem_ready && !rst;
        chk("mem_valid", {69'd0, mem_valid}, {69'd0, m_busy});
        chk("busy", {69'd0, busy}, {69'd0, m_busy});
        chk("imem_ready", {69'd0, imem_ready}, {69'd0, exp_ir});
        chk("dmem_ready", {69'd0, dmem_ready}, {69'd0, exp_dr});
        if (m_busy && exp_q.size() > 0) begin
            hd = exp_q[0];
            chk("mem_fields", {1'b0, mem_instr, mem_addr, mem_wdata, mem_wstrb}, {1'b0, hd[68:0]});
            if (exp_ir) chk("imem_rdata", {38'd0, imem_rdata}, {38'd0, mem_rdata});
            if (exp_dr) chk("dmem_rdata", {38'd0, dmem_rdata}, {38'd0, mem_rdata});
        end
        i_rdy_seen = imem_ready;
        d_rdy_seen = dmem_ready;
        mv_seen    = mem_valid;

        if (rst) begin
            m_busy = 1'b0;
            m_fav  = 1'b1;
            exp_q.delete();
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (imem_valid || dmem_valid) begin
            if (imem_valid && dmem_valid) begin
                win   = m_fav;
                m_fav = !m_fav;
            end else begin
                win = dmem_valid;
            end
            if (win) exp_q.push_back({1'b1, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb});
            else     exp_q.push_back({1'b0, imem_instr, imem_addr, imem_wdata, imem_wstrb});
            grant_log.push_back(win);
            m_busy = 1'b1;
            m_side = win;
        end

        if (f_on || f_busy_m) begin
            chk("fp_mem_valid", {69'd0, f_mem_valid}, {69'd0, f_busy_m});
            chk("fp_busy", {69'd0, f_busy}, {69'd0, f_busy_m});
            chk("fp_imem_ready", {69'd0, f_imem_ready}, {69'd0, f_busy_m && f_on && !rst});
            chk("fp_dmem_ready", {69'd0, f_dmem_ready}, 70'd0);
            if (f_busy_m)
                chk("fp_fields", {1'b0, f_mem_instr, f_mem_addr, f_mem_wdata, f_mem_wstrb},
                    {1'b0, 1'b1, F_IADDR, 32'h1111_1111, 4'h0});
            if (f_imem_ready) begin
                chk("fp_imem_rdata", {38'd0, f_imem_rdata}, {38'd0, 32'h5A5A_0000});
                f_i_cnt++;
            end
        end
        if (rst)           f_busy_m = 1'b0;
        else if (f_busy_m) f_busy_m = !f_on;
        else               f_busy_m = f_on;
    end

    // Requester and memory drivers, stepped just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (req_mode != 3) begin
                if (rst) begin
                    imem_valid = 1'b0;
                    dmem_valid = 1'b0;
                end else begin
                    if (imem_valid) begin
                        if (i_rdy_seen) imem_valid = 1'b0;
                    end else if (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 2) == 0)) begin
                        imem_valid = 1'b1;
                        imem_instr = 1'($urandom_range(0, 1));
                        imem_addr  = $urandom;
                        imem_wdata = $urandom;
                        imem_wstrb = 4'($urandom_range(0, 15));
                    end
                    if (dmem_valid) begin
                        if (d_rdy_seen) dmem_valid = 1'b0;
                    end else if (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 2) == 0)) begin
                        dmem_valid = 1'b1;
                        dmem_instr = 1'($urandom_range(0, 1));
                        dmem_addr  = $urandom;
                        dmem_wdata = $urandom;
                        dmem_wstrb = 4'($urandom_range(0, 15));
                    end
                end
            end
            case (mem_mode)
                0: mem_ready = 1'b0;
                1: begin
                    mem_ready = ($urandom_range(0, 3) == 0);
                    mem_rdata = $urandom;
                end
                2: begin
                    mem_ready = mv_seen && mem_valid;
                    mem_rdata = $urandom;
                end
                default: ;
            endcase
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic go_manual();
        req_mode   = 3;
        mem_mode   = 3;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;
        do_reset();
    endtask

    bit exp_seq[4];

    initial begin
        rst        = 1'b1;
        f_on       = 1'b0;
        imem_valid = 1'b0; imem_instr = 1'b0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 1'b0; dmem_instr = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        mem_ready  = 1'b0; mem_rdata  = '0;
        repeat (2) cycle();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_mem_fields", {1'b0, mem_instr, mem_addr, mem_wdata, mem_wstrb}, 70'd0);
        chk("rst_busy", {69'd0, busy}, 70'd0);

        // Single instruction read.
        go_manual();
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h100; imem_wdata = '0; imem_wstrb = 4'h0;
        repeat (3) cycle();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_mem_valid", {69'd0, mem_valid}, 70'd1);
        chk("t1_mem_addr", {38'd0, mem_addr}, {38'd0, 32'h100});
        chk("t1_mem_instr", {69'd0, mem_instr}, 70'd1);
        chk("t1_imem_ready", {69'd0, imem_ready}, 70'd1);
        chk("t1_imem_rdata", {38'd0, imem_rdata}, {38'd0, 32'hDEAD_BEEF});
        chk("t1_dmem_ready", {69'd0, dmem_ready}, 70'd0);
        cycle();
        mem_ready = 1'b0; imem_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_valid_after", {69'd0, mem_valid}, 70'd0);

        // Round-robin contention with continuous re-requests.
        req_mode = 2; mem_mode = 2;
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) cycle();
        chk("rr_grant_count", {69'd0, grant_log.size() >= 4}, 70'd1);
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        if (grant_log.size() >= 4)
            for (int k = 0; k < 4; k++) chk($sformatf("rr_order_%0d", k), {69'd0, grant_log[k]}, {69'd0, exp_seq[k]});

        // Data-side write pass-through, inputs scrambled after grant.
        go_manual();
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h2000_0004;
        dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'b0011;
        cycle();
        dmem_addr = 32'hFFFF_0000; dmem_wdata = 32'hCAFE_F00D; dmem_wstrb = 4'hF;
        cycle();
        @(negedge clk);
        chk("t4_fields", {1'b0, mem_instr, mem_addr, mem_wdata, mem_wstrb},
            {1'b0, 1'b0, 32'h2000_0004, 32'h1234_5678, 4'b0011});
        cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t4_dmem_ready", {69'd0, dmem_ready}, 70'd1);
        cycle();
        mem_ready = 1'b0; dmem_valid = 1'b0;

        // Reset while the data side owns the port.
        go_manual();
        dmem_valid = 1'b1; dmem_addr = 32'h40; dmem_wstrb = 4'h0;
        cycle();
        cycle();
        rst = 1'b1; dmem_valid = 1'b0;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_mem_valid", {69'd0, mem_valid}, 70'd0);
        chk("t5_busy", {69'd0, busy}, 70'd0);
        cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_dmem_ready", {69'd0, dmem_ready}, 70'd0);
        cycle();
        mem_ready = 1'b0;

        // Spurious mem_ready while idle.
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_readies", {68'd0, imem_ready, dmem_ready}, 70'd0);
            chk("t6_busy", {69'd0, busy}, 70'd0);
            cycle();
        end
        mem_ready = 1'b0;

        // Fixed priority: every grant to the instruction side.
        f_on = 1'b1;
        repeat (40) cycle();
        f_on = 1'b0;
        cycle();
        chk("fp_grant_count", {38'd0, 32'(f_i_cnt)}, {38'd0, 32'd20});

        // Randomized traffic with occasional resets.
        req_mode = 1; mem_mode = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle();
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        req_mode = 0;
        repeat (60) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-to-one arbiter that merges the core's instruction-side and data-side memory requests onto a single shared memory port.
- Used for single-ported memory systems. It sits between the cpu's imemory/dmemory ports and the external memory.
- Requests are registered at grant. Only one transaction is outstanding at a time.
- Selection is round-robin, or fixed-priority when configured.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = fixed priority.
- DMEM_FIRST, 1, priority winner when ROUND_ROBIN=0, and the initial favoured side after reset (1 = data side).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- imem_valid  input  1  instruction-side request; held until imem_ready
- imem_instr  input  1  request is an instruction fetch
- imem_addr  input  32  byte address
- imem_wdata  input  32  write data
- imem_wstrb  input  4  byte write strobes; 0 = read
- imem_rdata  output  32  read data
- imem_ready  output  1  completion pulse, 1 cycle
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb  input  1/1/32/32/4  data-side request, same meaning as imem_*
- dmem_rdata  output  32  read data
- dmem_ready  output  1  completion pulse, 1 cycle
- mem_valid  output  1  shared-port request
- mem_instr  output  1  latched instr flag
- mem_addr  output  32  latched address
- mem_wdata  output  32  latched write data
- mem_wstrb  output  4  latched strobes
- mem_rdata  input  32  shared-port read data
- mem_ready  input  1  shared-port completion
- busy  output  1  a transaction is in flight (state != IDLE)

Behaviour:
- States:
  - IDLE: no transaction.
  - GNT_I: instruction side owns the port.
  - GNT_D: data side owns the port.
- Reset, applied synchronously on any clk edge with rst=1, including mid-transaction:
  - state=IDLE.
  - mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Favour pointer = DMEM_FIRST.
  - imem_ready=0, dmem_ready=0, busy=0.
  - Any in-flight transaction is abandoned; no ready is issued for it.
- IDLE, cycle N, with at least one valid request:
  - Select a requester. The winner's instr/addr/wdata/wstrb are registered.
  - State goes to GNT_x at N+1. mem_valid=1 from N+1.
  - Request-to-mem_valid latency is 1 cycle.
- Selection rules:
  - Only one side valid: that side wins.
  - Both valid, ROUND_ROBIN=1: the favoured side wins; the favour pointer flips to the other side at grant.
  - Both valid, ROUND_ROBIN=0: the data side wins if DMEM_FIRST=1, otherwise the instruction side; the pointer is unused.
- GNT_x:
  - mem_* outputs hold the latched values; they stay stable regardless of requester inputs.
  - In a cycle M with mem_ready=1:
    - x_ready=1 combinationally in cycle M.
    - x_rdata=mem_rdata in cycle M.
    - State goes to IDLE at M+1; mem_valid=0 at M+1.
  - The other side's ready stays 0.
- Read data routing:
  - imem_rdata and dmem_rdata both carry mem_rdata at all times.
  - Only the ready signal qualifies the data.
- Back-to-back transactions:
  - Minimum gap is one IDLE cycle: grant evaluated at M+1, mem_valid at M+2.
  - Requesters drop valid in the cycle after ready; a requester still valid at M+1 is treated as a new request.
- Requester valid deasserted while granted (protocol violation):
  - The transaction still completes on the memory side and ready is still pulsed.
  - No assertion is raised by the RTL.
- mem_ready while IDLE: ignored; no ready output.
- mem_ready in the same cycle as the grant decision (IDLE): ignored, because mem_valid is not yet high.
- No timeout: GNT_x waits indefinitely for mem_ready.
- Writes: wstrb≠0 is passed through; the rdata returned on a write is don't-care.

Test Plan:
1. Reset then a single read: imem_valid=1, addr=0x100, wstrb=0 at cycle 2; memory ready at cycle 5 with rdata=0xDEADBEEF.
   - mem_valid=1 on cycles 3–5, mem_addr=0x100, mem_instr=1.
   - imem_ready=1 only in cycle 5, imem_rdata=0xDEADBEEF.
   - dmem_ready stays 0. mem_valid=0 at cycle 6.
2. Contention with ROUND_ROBIN=1 and both sides continuously re-requesting; memory ready 1 cycle after each mem_valid.
   - Grant order is D, I, D, I.
   - Each transaction shows the required IDLE gap cycle.
3. Contention with ROUND_ROBIN=0, DMEM_FIRST=0, both sides continuously requesting.
   - Every grant goes to the instruction side.
   - dmem_ready never asserts.
4. Write pass-through: dmem addr=0x2000_0004, wdata=0x12345678, wstrb=4'b0011.
   - The mem_* outputs carry exactly these values.
   - Changing the dmem inputs after grant does not change mem_addr or mem_wdata.
5. Reset mid-op: rst=1 while in GNT_D before mem_ready.
   - The next cycle has mem_valid=0 and busy=0.
   - A later mem_ready pulse produces no dmem_ready.
6. Spurious mem_ready=1 while IDLE with no requests.
   - imem_ready and dmem_ready stay 0; state stays IDLE.
